// File: rtl/gpio_avalon_bridge.sv
// Avalon-MM slave front end that turns Avalon reads/writes into the GPIO decoder's
// strobe-style register bus, with a guaranteed strobe-low gap between accesses.
module gpio_avalon_bridge #(
  parameter int AddrWidth   = 16,
  parameter int BusWidth    = 32,
  parameter int ReadLatency = 4,
  parameter int WriteHold   = 1
) (
  input  logic                 reg_clk,
  input  logic                 reset_in,
  input  logic [AddrWidth-3:0] avs_address,
  input  logic                 avs_write,
  input  logic                 avs_read,
  input  logic [BusWidth-1:0]  avs_writedata,
  output logic                 avs_waitrequest,
  output logic [BusWidth-1:0]  avs_readdata,
  output logic                 avs_readdatavalid,
  output logic                 chip_sel,
  output logic                 write_reg,
  output logic                 read_reg,
  output logic [AddrWidth-3:0] busaddress,
  output logic [BusWidth-1:0]  busdata_in,
  input  logic [BusWidth-1:0]  busdata_out,
  output logic                 proto_err,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE_RST = 3'd0,
    IDLE     = 3'd1,
    WR       = 3'd2,
    RD       = 3'd3,
    RD_WAIT  = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [3:0] WrLoad = 4'(WriteHold - 1);
  localparam logic [3:0] RdLoad = 4'(ReadLatency - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   waitrequest_q, waitrequest_d;
  logic [BusWidth-1:0]    readdata_q, readdata_d;
  logic                   readdatavalid_q, readdatavalid_d;
  logic                   chip_sel_q, chip_sel_d;
  logic                   write_reg_q, write_reg_d;
  logic                   read_reg_q, read_reg_d;
  logic [AddrWidth-3:0]   busaddress_q, busaddress_d;
  logic [BusWidth-1:0]    busdata_in_q, busdata_in_d;
  logic                   proto_err_q, proto_err_d;

  // Handshake: a command is taken on the clock edge where avs_write or avs_read is
  // high while avs_waitrequest is low; commands seen while waitrequest is high are ignored.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    waitrequest_d   = waitrequest_q;
    readdata_d      = readdata_q;
    readdatavalid_d = 1'b0;
    chip_sel_d      = chip_sel_q;
    write_reg_d     = write_reg_q;
    read_reg_d      = read_reg_q;
    busaddress_d    = busaddress_q;
    busdata_in_d    = busdata_in_q;
    proto_err_d     = proto_err_q;
    case (state_q)
      IDLE_RST: begin
        state_d       = IDLE;
        waitrequest_d = 1'b0;
      end
      IDLE: begin
        if (avs_write || avs_read) begin
          busaddress_d  = avs_address;
          waitrequest_d = 1'b1;
          chip_sel_d    = 1'b1;
          if (avs_write) begin
            // A write wins over a simultaneous read; the read is dropped and flagged.
            busdata_in_d = avs_writedata;
            write_reg_d  = 1'b1;
            cnt_d        = WrLoad;
            state_d      = WR;
            if (avs_read) proto_err_d = 1'b1;
          end else begin
            read_reg_d = 1'b1;
            cnt_d      = RdLoad;
            state_d    = RD;
          end
        end
      end
      WR: begin
        if (cnt_q == 4'd0) begin
          chip_sel_d  = 1'b0;
          write_reg_d = 1'b0;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        state_d       = IDLE;
        waitrequest_d = 1'b0;
      end
      RD: begin
        chip_sel_d = 1'b0;
        read_reg_d = 1'b0;
        cnt_d      = cnt_q - 4'd1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          readdata_d      = busdata_out;
          readdatavalid_d = 1'b1;
          waitrequest_d   = 1'b0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d       = IDLE_RST;
        waitrequest_d = 1'b1;
        chip_sel_d    = 1'b0;
        write_reg_d   = 1'b0;
        read_reg_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      state_q         <= IDLE_RST;
      cnt_q           <= 4'd0;
      waitrequest_q   <= 1'b1;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      chip_sel_q      <= 1'b0;
      write_reg_q     <= 1'b0;
      read_reg_q      <= 1'b0;
      busaddress_q    <= '0;
      busdata_in_q    <= '0;
      proto_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      waitrequest_q   <= waitrequest_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      chip_sel_q      <= chip_sel_d;
      write_reg_q     <= write_reg_d;
      read_reg_q      <= read_reg_d;
      busaddress_q    <= busaddress_d;
      busdata_in_q    <= busdata_in_d;
      proto_err_q     <= proto_err_d;
    end
  end

  assign avs_waitrequest   = waitrequest_q;
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;
  assign chip_sel          = chip_sel_q;
  assign write_reg         = write_reg_q;
  assign read_reg          = read_reg_q;
  assign busaddress        = busaddress_q;
  assign busdata_in        = busdata_in_q;
  assign proto_err         = proto_err_q;
  assign dbg_state         = state_q;

endmodule

// File: doc/gpio_avalon_bridge.md
Name: gpio_avalon_bridge

Overview:
- Avalon-MM slave front end for the GPIO register decoder. Converts HPS/FPGA-fabric Avalon reads and writes into the decoder's strobe-style register bus (chip_sel, write_reg, read_reg, busaddress, busdata_in).
- Returns read data by sampling the decoder's busdata_out after a fixed pipeline latency.
- Guarantees a strobe-low gap between accesses, because the decoder edge-triggers on its write/read strobes.

Parameters:
- AddrWidth, 16, byte-address width; the Avalon side carries word address [AddrWidth-1:2].
- BusWidth, 32, data width.
- ReadLatency, 4, cycles from read_reg assertion to valid busdata_out. Legal range 2..15.
- WriteHold, 1, cycles that write_reg/chip_sel stay high per write. Legal range 1..7.

Ports:
- reg_clk  in  1  register-bus clock.
- reset_in  in  1  asynchronous, active-high reset.
- avs_address  in  AddrWidth-2  Avalon word address.
- avs_write  in  1  Avalon write request.
- avs_read  in  1  Avalon read request.
- avs_writedata  in  BusWidth  Avalon write data.
- avs_waitrequest  out  1  high = command not accepted.
- avs_readdata  out  BusWidth  read data.
- avs_readdatavalid  out  1  one-cycle read-data qualifier.
- chip_sel  out  1  decoder chip select.
- write_reg  out  1  decoder write strobe.
- read_reg  out  1  decoder read strobe.
- busaddress  out  AddrWidth-2  word address to the decoder.
- busdata_in  out  BusWidth  write data to the decoder.
- busdata_out  in  BusWidth  read data from the decoder.
- proto_err  out  1  sticky flag: avs_read and avs_write seen together.

Behaviour:
- Reset values:
  - state = IDLE_RST.
  - avs_waitrequest = 1.
  - All other outputs = 0, including proto_err.
  - Reset mid-transaction aborts it: no avs_readdatavalid is issued and the strobes drop immediately.
- Outputs: all registered. No combinational path from avs_* to any output.
- Cycle numbering: cycle n is the interval following clock edge n.
- States: IDLE_RST, IDLE, WR, RD, RD_WAIT, GAP.
- IDLE_RST: first cycle after reset release; next state IDLE, where avs_waitrequest becomes 0.
- IDLE (avs_waitrequest = 0):
  - A command is accepted at edge T when avs_write or avs_read is high.
  - On acceptance, latch avs_address → busaddress and avs_writedata → busdata_in (write only).
  - busaddress and busdata_in hold until the next acceptance.
  - From cycle T+1, avs_waitrequest = 1.
- Simultaneous avs_write and avs_read in IDLE: the write executes, the read is dropped, proto_err = 1. proto_err clears only on reset.
- WR (write accepted at T):
  - chip_sel = write_reg = 1 for cycles T+1 .. T+WriteHold.
  - Then GAP.
- RD (read accepted at T):
  - chip_sel = read_reg = 1 in cycle T+1 only.
  - Then RD_WAIT, with a 4-bit down-counter loaded with ReadLatency-1.
- RD_WAIT: when the count reaches 0 (edge T+ReadLatency):
  - Sample busdata_out → avs_readdata.
  - Assert avs_readdatavalid for exactly cycle T+ReadLatency+1.
  - Go to IDLE in that same cycle, so avs_waitrequest = 0 there.
  - read_reg's own low period guarantees the strobe gap.
  - avs_readdata holds its value until the next read capture.
- GAP: one cycle with all strobes 0, then IDLE. Back-to-back writes therefore always show a rising write_reg edge.
- Throughput:
  - Write: WriteHold+2 cycles (accept to next accept).
  - Read: ReadLatency+1 cycles.
- Command held across waitrequest: an Avalon command held high while avs_waitrequest = 1 is not re-sampled; it is accepted only in IDLE.
- Address arithmetic: none. The word address passes through unmodified; the decoder appends the byte bits.

Test Plan:
- Reset release → avs_waitrequest is 1 in the first cycle, 0 in the second; all strobes 0; proto_err 0.
- Write addr 0x440 (byte 0x1100), data 0x00FFFFFF, WriteHold=1:
  - busaddress = 0x440, busdata_in = 0x00FFFFFF, write_reg/chip_sel high exactly 1 cycle at T+1.
  - GAP at T+2; avs_waitrequest low at T+3.
- Two back-to-back writes (0x440, then 0x441 = 0x12):
  - write_reg shows two separate 1-cycle pulses separated by ≥1 low cycle.
  - Second busdata_in = 0x12.
- Read addr 0x448 with busdata_out driven 0x0C0D0E0F, ReadLatency=4:
  - read_reg high only at T+1.
  - avs_readdatavalid high only at T+5, with avs_readdata = 0x0C0D0E0F.
- avs_read and avs_write both high with data 0xA5 → one write_reg pulse, no avs_readdatavalid, proto_err = 1 and it stays 1 until reset.
- reset_in pulsed at T+2 of a read → read_reg/chip_sel 0 immediately; avs_readdatavalid never asserts; normal reset sequence follows.
